// File: rtl/dram_mmio_pkg.sv
// dram_mmio_pkg: shared types and address-map helpers for dram_mmio.
// The I/O window starts at IO_BASE. Input ports come first, then output
// ports, then the STATUS register. The offset helpers take the port counts
// as arguments because a package cannot see module parameters.
package dram_mmio_pkg;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_IN,
    REG_OUT,
    REG_STATUS,
    REG_NONE
  } region_e;

  function automatic int in_ofs();
    return 0;
  endfunction

  function automatic int out_ofs(input int n_in);
    return n_in;
  endfunction

  function automatic int status_ofs(input int n_in, input int n_out);
    return n_in + n_out;
  endfunction

endpackage

// File: rtl/mmio_in_port.sv
// mmio_in_port: one input port lane.
// It samples the port every cycle into in_q, so the value read back lags
// the pin by one cycle. Built with DRAM_MMIO_STATUS_EN, it also keeps a
// sticky change-detect bit that is cleared by writing 1 (W1C). If a set
// and a clear land on the same edge, the set wins.
// Ports:
//   clk, rst       : clock and synchronous active-high reset
//   in_port        : raw port value
//   in_q           : sampled value
//   status_clr     : W1C clear request (macro only)
//   status         : change-detect bit (macro only)
module mmio_in_port #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_port,
`ifdef DRAM_MMIO_STATUS_EN
  input  logic              status_clr,
  output logic              status,
`endif
  output logic [DATA_W-1:0] in_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q <= '0;
    end else begin
      in_q <= in_port;
    end
  end

`ifdef DRAM_MMIO_STATUS_EN
  // Compare against the old in_q: this is the edge where the new value
  // gets sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      status <= 1'b0;
    end else if (in_port != in_q) begin
      status <= 1'b1;
    end else if (status_clr) begin
      status <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/dram_mmio.sv
// dram_mmio: data RAM with memory-mapped I/O for the single-cycle CPU.
// Address map (word addresses):
//   [0, IO_BASE)                 RAM
//   IO_BASE + i                  sampled input port i
//   IO_BASE + N_IN + j           output port register j
//   IO_BASE + N_IN + N_OUT       STATUS (only with DRAM_MMIO_STATUS_EN)
//   anything else                unmapped: reads 0, writes are ignored
// Reads are combinational. Writes take effect on the rising edge of CLK
// when MW=1. An output-port write pulses OUT_STB[j] for one cycle.
// Ports:
//   CLK, RESET : clock and synchronous active-high reset
//   ADDR, DATA : word address and write data
//   MW         : write enable
//   Q          : read data
//   IN_PORTS   : input ports, port i at [i*DATA_W +: DATA_W]
//   OUT_PORTS  : output port registers, same packing
//   OUT_STB    : per-output write strobe
// Optional macro: DRAM_MMIO_STATUS_EN enables the change-detect STATUS register.
module dram_mmio
  import dram_mmio_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int IO_BASE = 'hF0,
  parameter int N_IN    = 3,
  parameter int N_OUT   = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [ADDR_W-1:0]       ADDR,
  input  logic [DATA_W-1:0]       DATA,
  input  logic                    MW,
  output logic [DATA_W-1:0]       Q,
  input  logic [N_IN*DATA_W-1:0]  IN_PORTS,
  output logic [N_OUT*DATA_W-1:0] OUT_PORTS,
  output logic [N_OUT-1:0]        OUT_STB
);

  localparam int RAM_AW = (IO_BASE > 1) ? $clog2(IO_BASE) : 1;
  localparam logic [ADDR_W-1:0] IN_BASE  = ADDR_W'(IO_BASE + in_ofs());
  localparam logic [ADDR_W-1:0] OUT_BASE = ADDR_W'(IO_BASE + out_ofs(N_IN));
`ifdef DRAM_MMIO_STATUS_EN
  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(IO_BASE + status_ofs(N_IN, N_OUT));
`endif

  if (IO_BASE + N_IN + N_OUT + 1 > (1 << ADDR_W)) begin : g_map_too_big
    $error("dram_mmio: I/O window does not fit in the address space");
  end
  if (N_IN < 1 || N_IN > DATA_W || N_OUT < 1) begin : g_bad_ports
    $error("dram_mmio: N_IN must be 1..DATA_W and N_OUT must be >= 1");
  end

  logic [DATA_W-1:0]             ram [IO_BASE];
  logic [N_OUT-1:0][DATA_W-1:0]  out_reg;
  logic [N_IN-1:0][DATA_W-1:0]   in_q;
  logic [N_IN-1:0]               in_hit;
  logic [N_OUT-1:0]              out_hit;
  logic [RAM_AW-1:0]             ram_idx;
  region_e                       region;

  // RAM_AW never exceeds ADDR_W. The index only matters inside the RAM
  // region, so any out-of-range value it takes elsewhere is never used.
  assign ram_idx = ADDR[RAM_AW-1:0];

  // Address decode. All compares use full-width ADDR, so there is no
  // aliasing. The regions are disjoint, so at most one branch hits.
  always_comb begin
    region  = REG_NONE;
    in_hit  = '0;
    out_hit = '0;
    if (ADDR < IN_BASE) region = REG_RAM;
    for (int i = 0; i < N_IN; i++) begin
      if (ADDR == IN_BASE + ADDR_W'(i)) begin
        region    = REG_IN;
        in_hit[i] = 1'b1;
      end
    end
    for (int j = 0; j < N_OUT; j++) begin
      if (ADDR == OUT_BASE + ADDR_W'(j)) begin
        region     = REG_OUT;
        out_hit[j] = 1'b1;
      end
    end
`ifdef DRAM_MMIO_STATUS_EN
    if (ADDR == STATUS_ADDR) region = REG_STATUS;
`endif
  end

  // Input lanes
`ifdef DRAM_MMIO_STATUS_EN
  logic [N_IN-1:0] status;
  logic [N_IN-1:0] status_clr;
  assign status_clr = (MW && region == REG_STATUS) ? DATA[N_IN-1:0] : '0;
`endif

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    mmio_in_port #(.DATA_W(DATA_W)) u_in (
      .clk        (CLK),
      .rst        (RESET),
      .in_port    (IN_PORTS[i*DATA_W +: DATA_W]),
`ifdef DRAM_MMIO_STATUS_EN
      .status_clr (status_clr[i]),
      .status     (status[i]),
`endif
      .in_q       (in_q[i])
    );
  end

  // Read mux
  always_comb begin
    Q = '0;
    case (region)
      REG_RAM: Q = ram[ram_idx];
      REG_IN: begin
        for (int i = 0; i < N_IN; i++) if (in_hit[i]) Q = in_q[i];
      end
      REG_OUT: begin
        for (int j = 0; j < N_OUT; j++) if (out_hit[j]) Q = out_reg[j];
      end
`ifdef DRAM_MMIO_STATUS_EN
      REG_STATUS: Q[N_IN-1:0] = status;
`endif
      default: Q = '0;
    endcase
  end

  // RAM and output registers. Reset takes priority over a write on the same edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < IO_BASE; k++) ram[k] <= '0;
      out_reg <= '0;
      OUT_STB <= '0;
    end else begin
      OUT_STB <= '0;
      if (MW && region == REG_RAM) ram[ram_idx] <= DATA;
      for (int j = 0; j < N_OUT; j++) begin
        if (MW && out_hit[j]) begin
          out_reg[j] <= DATA;
          OUT_STB[j] <= 1'b1;
        end
      end
    end
  end

  assign OUT_PORTS = out_reg;

endmodule

// File: doc/dram_mmio.md
# dram_mmio

Parametrised data memory with memory-mapped I/O for the single-cycle CPU. It replaces the fixed 8-bit, three-input/four-output data RAM and generalises data width, address width, RAM depth and the number of input and output ports. It adds registered input sampling, per-output write strobes, and an optional change-detect status register. It sits on the CPU data bus: address from DataD, write data from DataB, read data to Din.

## Interface
- DATA_W, 8, data and port width in bits
- ADDR_W, 8, address width; address space is 2^ADDR_W words
- IO_BASE, 'hF0, first I/O address; RAM occupies 0..IO_BASE-1
- N_IN, 3, number of input ports (1..DATA_W)
- N_OUT, 4, number of output ports (≥1)
- Constraint: IO_BASE + N_IN + N_OUT + 1 ≤ 2^ADDR_W (checked at elaboration)

Ports:
- CLK  in  1  single clock, rising edge
- RESET  in  1  synchronous, active-high reset
- ADDR  in  ADDR_W  word address
- DATA  in  DATA_W  write data
- MW  in  1  memory write enable
- Q  out  DATA_W  read data, combinational from ADDR
- IN_PORTS  in  N_IN*DATA_W  input ports; port i occupies bits [i*DATA_W +: DATA_W]
- OUT_PORTS  out  N_OUT*DATA_W  output port registers, same packing
- OUT_STB  out  N_OUT  one-cycle pulse per output port when that port is written

## Operation
- Address map:
  - RAM: [0, IO_BASE)
  - Input port i: IO_BASE+i
  - Output port j: IO_BASE+N_IN+j
  - STATUS: IO_BASE+N_IN+N_OUT
  - Every other address is unmapped.
- Reads are combinational. Q is the selected source:
  - RAM word
  - sampled input register in_q[i] (not raw IN_PORTS)
  - output register
  - STATUS
  - 0 for unmapped addresses
- Writes occur on the rising edge with MW=1:
  - RAM address: stores DATA.
  - Output port j: loads DATA into OUT_PORTS[j] and sets OUT_STB[j]=1 for the next cycle only.
  - Input port address, unmapped address, or STATUS with the macro off: ignored, with no side effects.
- Input sampling: in_q[i] <= IN_PORTS[i] every cycle. This gives one cycle of latency from a port change to a visible read value.
- OUT_STB is registered. OUT_PORTS holds its value until the next write or reset.
- Arithmetic: all address compares use ADDR_W-bit unsigned values. No address wrap occurs; out-of-range addresses are unmapped, never aliased.

## Timing
- Reset (RESET=1 at a rising edge):
  - all RAM words = 0
  - OUT_PORTS = 0, OUT_STB = 0
  - in_q = 0, STATUS = 0
  - Reset overrides any write in the same cycle.
- Read latency: 0 cycles (combinational) for RAM and for registers.
- Write-to-read: data written at edge k is visible on Q from edge k onward.
- Input latency: IN_PORTS value at edge k is readable after edge k.
- Back-to-back writes to the same output port give OUT_STB high on consecutive cycles.
- Reset asserted in the same cycle as a pending strobe clears the strobe.

## Configuration
- DRAM_MMIO_STATUS_EN
  - Defined:
    - STATUS[i] sets at any edge where the newly sampled IN_PORTS[i] differs from in_q[i].
    - Writing 1 to STATUS bit i clears it (write-1-to-clear); writing 0 has no effect.
    - Set and clear in the same cycle: set wins.
    - Bits ≥ N_IN read as 0.
  - Undefined: the STATUS address is unmapped and reads as 0; there is no change-detect logic.

## Structure
- Package dram_mmio_pkg holds:
  - offset constants IN_OFS=0, OUT_OFS=N_IN, STATUS_OFS=N_IN+N_OUT as functions of the parameters
  - an enum for the decoded region (RAM, IN, OUT, STATUS, NONE)
- One sub-module, mmio_in_port, instantiated N_IN times. It contains the sample register plus, under the macro, the change-detect/W1C status bit.
- Address decode, RAM array and output registers live in dram_mmio.

## Test plan
- Reset, then read addresses 0, IO_BASE-1 and IO_BASE+N_IN → Q=0, OUT_PORTS=0, OUT_STB=0.
- Write 'hA5 to address 3, read address 3 in the next cycle → Q='hA5. Write 'h11 to IO_BASE (input port) → in_q unchanged.
- Write 'h3C to IO_BASE+N_IN+1 → OUT_PORTS[1]='h3C one edge later, OUT_STB=4'b0010 for exactly one cycle. Then MW=0 → OUT_STB=0 and OUT_PORTS[1] holds.
- Drive IN_PORTS[2]='h7E → a read of IO_BASE+2 gives 'h7E only after the next edge.
- Macro on: toggle IN_PORTS[0] → STATUS reads 'h01. Write 'h01 to STATUS while IN_PORTS[0] changes again in the same cycle → STATUS stays 'h01. Write 'h01 with no change → 'h00.
- Assert RESET during a cycle where MW=1 targets output port 0 → OUT_PORTS[0]=0, OUT_STB=0 after the edge.
